// File: rtl/roll_removal_sequencer_pkg.sv
// Shared types and constants for the roll removal sequencer.
package roll_removal_sequencer_pkg;

    localparam int ROW_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME0   = 3'd1,
        PRIME1   = 3'd2,
        SWEEP    = 3'd3,
        PASS_END = 3'd4,
        DONE     = 3'd5
    } state_e;

    // The counter must hold every bit of the grid without wrapping.
    function automatic int cnt_w_for(input int rows);
        return $clog2(rows * ROW_W + 1);
    endfunction

endpackage

// File: rtl/roll_removal_sequencer_if.sv
// Row memory and window bus between the sequencer and its environment.
//
// There is no valid/ready handshake on this bus. The read port returns
// rd_data one cycle after rd_en. A write is taken in any cycle where wr_en
// is high. The window triple is meaningful while win_valid is high, and
// mask_in must answer it combinationally in the same cycle.
interface roll_removal_sequencer_if #(
    parameter int ADDR_W = 8
);
    import roll_removal_sequencer_pkg::*;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              win_valid;
    logic [ROW_W-1:0]  win_prev;
    logic [ROW_W-1:0]  win_cur;
    logic [ROW_W-1:0]  win_next;
    logic [ROW_W-1:0]  mask_in;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output win_valid, win_prev, win_cur, win_next,
        input  rd_data, mask_in
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  win_valid, win_prev, win_cur, win_next,
        output rd_data, mask_in
    );

endinterface

// File: rtl/count_ones_32.sv
// Population count of one 32-bit row.
module count_ones_32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Sum the set bits.
    always_comb begin
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + 6'(value[i]);
        end
    end

endmodule

// File: rtl/roll_removal_sequencer.sv
// Repeated-removal sweep over the row memory. Each pass streams the rows
// through a 3-row window, writes back each row with the accessible rolls
// cleared, and totals the removals until a pass removes nothing or the
// pass limit is hit.
module roll_removal_sequencer
    import roll_removal_sequencer_pkg::*;
#(
    parameter int ROWS       = 136,
    parameter int ADDR_W     = 8,
    parameter int MAX_PASSES = 255,
    parameter int CNT_W      = cnt_w_for(ROWS)
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     start,
    roll_removal_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         total_removed,
    output logic [7:0]               passes,
    output logic [2:0]               dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'(IDLE);
    localparam logic [2:0] S_PRIME0   = 3'(PRIME0);
    localparam logic [2:0] S_PRIME1   = 3'(PRIME1);
    localparam logic [2:0] S_SWEEP    = 3'(SWEEP);
    localparam logic [2:0] S_PASS_END = 3'(PASS_END);
    localparam logic [2:0] S_DONE     = 3'(DONE);

    logic [2:0]       state;
    logic [ADDR_W-1:0] row;
    logic [ROW_W-1:0] cur;
    logic [ROW_W-1:0] prev;
    logic [CNT_W-1:0] pass_cnt;

    logic             in_sweep;
    logic             last_row;
    logic             read_ahead;
    logic [ROW_W-1:0] eff;
    logic [ROW_W-1:0] kept;
    logic [5:0]       eff_ones;

    count_ones_32 u_count (
        .value (eff),
        .count (eff_ones)
    );

    // Window and memory port decode; everything is gated by state so that
    // reset silences the memory strobes immediately.
    always_comb begin
        in_sweep   = (state == S_SWEEP);
        last_row   = (row == ADDR_W'(ROWS - 1));
        read_ahead = ((ADDR_W + 1)'(row) + (ADDR_W + 1)'(2)) < (ADDR_W + 1)'(ROWS);
        eff        = bus.mask_in & cur;
        kept       = cur & ~eff;

        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        case (state)
            S_PRIME0: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = '0;
            end
            S_PRIME1: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = ADDR_W'(1);
            end
            S_SWEEP: begin
                bus.rd_en   = read_ahead;
                bus.rd_addr = read_ahead ? row + ADDR_W'(2) : '0;
            end
            default: ;
        endcase

        bus.wr_en     = in_sweep;
        bus.wr_addr   = in_sweep ? row : '0;
        bus.wr_data   = in_sweep ? kept : '0;
        bus.win_valid = in_sweep;
        bus.win_prev  = prev;
        bus.win_cur   = cur;
        bus.win_next  = (in_sweep && !last_row) ? bus.rd_data : '0;

        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    // Pass sequencing, window shift and removal accounting.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state         <= S_IDLE;
            row           <= '0;
            cur           <= '0;
            prev          <= '0;
            pass_cnt      <= '0;
            total_removed <= '0;
            passes        <= '0;
            timeout       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total_removed <= '0;
                        passes        <= '0;
                        timeout       <= 1'b0;
                        pass_cnt      <= '0;
                        state         <= S_PRIME0;
                    end
                end
                S_PRIME0: state <= S_PRIME1;
                S_PRIME1: begin
                    cur   <= bus.rd_data;
                    prev  <= '0;
                    row   <= '0;
                    state <= S_SWEEP;
                end
                S_SWEEP: begin
                    // prev holds the already-updated row for the next window.
                    prev     <= kept;
                    cur      <= bus.rd_data;
                    pass_cnt <= pass_cnt + CNT_W'(eff_ones);
                    if (last_row) begin
                        state <= S_PASS_END;
                    end else begin
                        row <= row + ADDR_W'(1);
                    end
                end
                S_PASS_END: begin
                    passes        <= passes + 8'd1;
                    total_removed <= total_removed + pass_cnt;
                    if (pass_cnt == '0) begin
                        state <= S_DONE;
                    end else if (({1'b0, passes} + 9'd1) == 9'(MAX_PASSES)) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        pass_cnt <= '0;
                        state    <= S_PRIME0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
